// File: rtl/pixel_stream_decoder.sv
// Purpose: passive decoder of the renderer's pixel-write bus; rebuilds runner/obstacle state per frame.
// Latency: results, frame_done and frame_count update one cycle after the x==0 pixel that closes a frame.
// Backpressure: none; pure listener, every plot=1 cycle is consumed and plot=0 cycles are ignored.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   x, y, colour      - pixel coordinates and colour, sampled only when plot=1
//   plot              - pixel valid
//   runner_low        - lowest runner offset of the last frame (0 when no runner seen)
//   runner_present    - runner pixels seen in columns 0..1 of the last frame
//   obst_height       - tallest obstacle offset inside the hit window
//   collision         - runner overlaps an obstacle in the hit window
//   frame_done        - one-cycle pulse when the result outputs update
//   frame_count       - completed frames, wrapping 16-bit counter
//   frame_err         - sticky protocol-violation flag, cleared only by reset
module pixel_stream_decoder #(
  parameter int unsigned BASE_Y        = 84,
  parameter logic [2:0]  RUNNER_COLOUR = 3'b100,
  parameter logic [2:0]  OBST_COLOUR   = 3'b110,
  parameter logic [2:0]  BG_COLOUR     = 3'b011,
  parameter int unsigned HIT_X_LO      = 2,
  parameter int unsigned HIT_X_HI      = 3,
  parameter int unsigned FRAME_PIXELS  = 652
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  output logic [3:0]  runner_low,
  output logic        runner_present,
  output logic [1:0]  obst_height,
  output logic        collision,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, RUNNER, FIELD, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  run_min, run_min_nxt;
  logic        run_seen, run_seen_nxt;
  logic [1:0]  obs_max, obs_max_nxt;
  logic [9:0]  pix_cnt, pix_cnt_nxt;
  logic [7:0]  last_x, last_x_nxt;
  logic [3:0]  runner_low_nxt;
  logic        runner_present_nxt;
  logic [1:0]  obst_height_nxt;
  logic        collision_nxt;
  logic [15:0] frame_count_nxt;
  logic        frame_err_nxt;

  // Pixel classification, shared by the runner and field paths.
  logic [6:0] off;
  logic       off_ok, col_ok, is_run, is_obs, in_hit;
  logic       run_viol, field_viol, run_hit;
  logic [9:0] cnt_inc;
  logic [3:0] commit_low;
  logic       commit_coll;

  assign off     = 7'(BASE_Y) - y;
  // y above the baseline wraps off to a large value, so off<=9 alone would
  // catch it; the explicit y check keeps the intent readable.
  assign off_ok  = (y <= 7'(BASE_Y)) && (off <= 7'd9);
  assign is_run  = (colour == RUNNER_COLOUR);
  assign is_obs  = (colour == OBST_COLOUR);
  assign col_ok  = is_run || is_obs || (colour == BG_COLOUR);
  assign in_hit  = (x >= 8'(HIT_X_LO)) && (x <= 8'(HIT_X_HI));

  assign run_viol   = !off_ok || !col_ok || (is_run && (off == 7'd0));
  assign field_viol = !off_ok || (off > 7'd3) || !col_ok || is_run || (is_obs && (off == 7'd0));
  // Only legal runner offsets 1..9 feed run_min, so runner_low stays in range.
  assign run_hit    = is_run && off_ok && (off != 7'd0);

  assign cnt_inc     = (pix_cnt == 10'h3FF) ? pix_cnt : pix_cnt + 10'd1;
  assign commit_low  = run_seen ? run_min : 4'd0;
  assign commit_coll = run_seen && (obs_max != 2'd0) && (commit_low <= {2'b00, obs_max});

  assign frame_done = (state == COMMIT);

  always_comb begin
    logic do_start, do_run, do_field, do_commit;
    do_start            = 1'b0;
    do_run              = 1'b0;
    do_field            = 1'b0;
    do_commit           = 1'b0;
    state_nxt           = state;
    run_min_nxt         = run_min;
    run_seen_nxt        = run_seen;
    obs_max_nxt         = obs_max;
    pix_cnt_nxt         = pix_cnt;
    last_x_nxt          = plot ? x : last_x;
    runner_low_nxt      = runner_low;
    runner_present_nxt  = runner_present;
    obst_height_nxt     = obst_height;
    collision_nxt       = collision;
    frame_count_nxt     = frame_count;
    frame_err_nxt       = frame_err;

    case (state)
      IDLE: begin
        if (plot && (x == 8'd0)) begin
          do_start  = 1'b1;
          do_run    = 1'b1;
          state_nxt = RUNNER;
        end
      end
      // COMMIT lasts exactly one cycle and decodes pixels like RUNNER, so a
      // new frame streams in without a gap.
      RUNNER, COMMIT: begin
        state_nxt = RUNNER;
        if (plot) begin
          if (x >= 8'd2) begin
            do_field  = 1'b1;
            state_nxt = FIELD;
          end else begin
            do_run = 1'b1;
          end
        end
      end
      FIELD: begin
        if (plot) begin
          if (x == 8'd0) begin
            do_commit = 1'b1;
            do_start  = 1'b1;
            do_run    = 1'b1;
            state_nxt = COMMIT;
          end else if (x >= last_x) begin
            do_field = 1'b1;
          end
          // A backwards step to a nonzero column is only counted.
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_commit) begin
      runner_low_nxt     = commit_low;
      runner_present_nxt = run_seen;
      obst_height_nxt    = obs_max;
      collision_nxt      = commit_coll;
      frame_count_nxt    = frame_count + 16'd1;
      if (pix_cnt != 10'(FRAME_PIXELS)) frame_err_nxt = 1'b1;
    end

    // The opening x==0 pixel is the first pixel of the new frame.
    if (do_start) begin
      run_min_nxt  = 4'hF;
      run_seen_nxt = 1'b0;
      obs_max_nxt  = 2'd0;
      pix_cnt_nxt  = 10'd1;
    end else if (plot && (state != IDLE)) begin
      pix_cnt_nxt = cnt_inc;
    end

    if (do_run) begin
      if (run_viol) frame_err_nxt = 1'b1;
      if (run_hit) begin
        run_seen_nxt = 1'b1;
        if (off[3:0] < run_min_nxt) run_min_nxt = off[3:0];
      end
    end

    if (do_field) begin
      if (field_viol) frame_err_nxt = 1'b1;
      if (is_obs && in_hit && (off <= 7'd3) && (off[1:0] > obs_max_nxt)) obs_max_nxt = off[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      run_min        <= 4'hF;
      run_seen       <= 1'b0;
      obs_max        <= 2'd0;
      pix_cnt        <= 10'd0;
      last_x         <= 8'd0;
      runner_low     <= 4'd0;
      runner_present <= 1'b0;
      obst_height    <= 2'd0;
      collision      <= 1'b0;
      frame_count    <= 16'd0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      run_min        <= run_min_nxt;
      run_seen       <= run_seen_nxt;
      obs_max        <= obs_max_nxt;
      pix_cnt        <= pix_cnt_nxt;
      last_x         <= last_x_nxt;
      runner_low     <= runner_low_nxt;
      runner_present <= runner_present_nxt;
      obst_height    <= obst_height_nxt;
      collision      <= collision_nxt;
      frame_count    <= frame_count_nxt;
      frame_err      <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_stream_decoder.sv
// Purpose: self-checking bench for pixel_stream_decoder; frames are built column by column
// (x=0..1 offsets 0..9, x=2..159 offsets 0..3 = 652 pixels) with random plot=0 gaps.
// Expected results are queued when a frame is driven and popped when frame_done fires.
module tb_pixel_stream_decoder;

  localparam int         BASE_Y = 84;
  localparam logic [2:0] RC = 3'b100;
  localparam logic [2:0] OC = 3'b110;
  localparam logic [2:0] BC = 3'b011;

  typedef struct packed {
    logic [3:0]  low;
    logic        present;
    logic [1:0]  obst;
    logic        coll;
    logic [15:0] cnt;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [3:0]  runner_low;
  logic        runner_present;
  logic [1:0]  obst_height;
  logic        collision;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_err;

  always #5 clk = ~clk;

  pixel_stream_decoder dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .runner_low(runner_low), .runner_present(runner_present), .obst_height(obst_height),
    .collision(collision), .frame_done(frame_done), .frame_count(frame_count),
    .frame_err(frame_err)
  );

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  res_t       exp_q[$];
  res_t       obs_q[$];
  logic [9:0] run_mask;
  int         obst_h [0:159];
  int         exp_count;
  logic       exp_err;

  function automatic res_t cur();
    return {runner_low, runner_present, obst_height, collision, frame_count, frame_err};
  endfunction

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      obs_q.push_back(cur());
      done_cnt++;
    end
  end

  // Reference model straight from the frame description.
  function automatic res_t model();
    res_t r;
    int   h;
    r = '0;
    for (int o = 9; o >= 1; o--) if (run_mask[o]) r.low = 4'(o);
    r.present = |run_mask[9:1];
    h = (obst_h[2] > obst_h[3]) ? obst_h[2] : obst_h[3];
    r.obst = 2'(h);
    r.coll = r.present && (h != 0) && (int'(r.low) <= h);
    r.cnt  = 16'(exp_count);
    r.err  = exp_err;
    return r;
  endfunction

  task automatic send_pixel(input logic [7:0] px, input int off, input logic [2:0] c);
    if ($urandom_range(0, 7) == 0) begin
      plot = 1'b0;
      x = 8'($urandom);
      y = 7'($urandom);
      colour = 3'($urandom);
      @(posedge clk); #1;
    end
    plot = 1'b1;
    x = px;
    y = 7'(BASE_Y - off);
    colour = c;
    @(posedge clk); #1;
    plot = 1'b0;
  endtask

  task automatic send_open();
    send_pixel(8'd0, 0, BC);
  endtask

  // Drives a frame body (everything after the opening x==0 pixel) up to column max_x.
  // bad: 0 clean, 1 illegal colour, 2 y below baseline; drop removes the last pixel.
  task automatic send_body(input bit drop, input int bad, input int max_x);
    int lim, o0, oo;
    logic [2:0] c;
    for (int xx = 0; xx <= max_x; xx++) begin
      lim = (xx < 2) ? 9 : 3;
      o0  = (xx == 0) ? 1 : 0;
      for (int o = o0; o <= lim; o++) begin
        oo = o;
        if (xx < 2) c = run_mask[o] ? RC : BC;
        else        c = (o >= 1 && o <= obst_h[xx]) ? OC : BC;
        if (bad == 1 && xx == 5 && o == 1) c = 3'b111;
        if (bad == 2 && xx == 5 && o == 1) oo = -6;
        if (!(drop && xx == 159 && o == 3)) send_pixel(8'(xx), oo, c);
      end
    end
    if (max_x == 159) begin
      exp_count++;
      if (drop || bad != 0) exp_err = 1'b1;
      exp_q.push_back(model());
    end
  endtask

  task automatic wait_result(output res_t got, output bit ok);
    int n;
    ok = 1'b0;
    got = 'x;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); #1;
      if (obs_q.size() > 0) begin
        got = obs_q.pop_front();
        ok = 1'b1;
      end
      n++;
    end
  endtask

  function automatic res_t pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  task automatic clear_scene();
    run_mask = '0;
    foreach (obst_h[i]) obst_h[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plot = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    exp_count = 0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cur() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", cur()); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
    send_open();
  endtask

  task automatic test_clean_collide();
    res_t got, e; bit ok;
    clear_scene();
    run_mask = 10'b00000_11110;
    obst_h[2] = 1;
    send_body(0, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL clean_collide: got %h expected %h", got, e); end
  endtask

  task automatic test_clear_jump();
    res_t got, e; bit ok;
    clear_scene();
    run_mask = 10'b01111_00000;
    obst_h[2] = 3; obst_h[3] = 2; obst_h[7] = 1;
    send_body(0, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL clear_jump: got %h expected %h", got, e); end
  endtask

  task automatic test_outside_window();
    res_t got, e; bit ok;
    clear_scene();
    run_mask = 10'b00000_00010;
    obst_h[10] = 3;
    send_body(0, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL outside_window: got %h expected %h", got, e); end
  endtask

  task automatic test_back_to_back();
    res_t got, e, prev; bit ok;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      clear_scene();
      if (i == 0) begin
        run_mask = 10'b00000_00100;  // runner_low equals obstacle height
        obst_h[3] = 2;
      end else begin
        run_mask = 10'($urandom_range(0, 1023)) & 10'h3FE;
        for (int c = 2; c <= 12; c++) obst_h[c] = $urandom_range(0, 3);
      end
      send_body(0, 0, 159);
      if (i > 0) begin
        checks++;
        if (cur() !== prev) begin errors++; $display("FAIL hold_between_frames[%0d]: got %h expected %h", i, cur(), prev); end
      end
      send_open();
      wait_result(got, ok); e = pop_exp();
      checks++;
      if (!ok || got !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, e); end
      prev = e;
    end
  endtask

  task automatic test_short_frame();
    res_t got, e; bit ok;
    clear_scene();
    run_mask = 10'b00001_00000;
    obst_h[2] = 2;
    send_body(1, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL short_frame: got %h expected %h", got, e); end
    send_body(0, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL err_sticky: got %h expected %h", got, e); end
  endtask

  task automatic test_bad_pixel(input int kind);
    res_t got, e; bit ok;
    do_reset();
    send_open();
    clear_scene();
    run_mask = 10'b00000_00010;
    obst_h[3] = 1;
    send_body(0, kind, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL bad_pixel[%0d]: got %h expected %h", kind, got, e); end
  endtask

  task automatic test_mid_reset();
    res_t got, e; bit ok;
    int d0;
    clear_scene();
    run_mask = 10'b00000_01000;
    obst_h[3] = 2;
    send_body(0, 0, 60);
    reset = 1'b1;
    send_pixel(8'd0, 0, BC);
    send_pixel(8'd3, 1, OC);
    checks++;
    if (cur() !== '0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h/%b expected 0/0", cur(), frame_done);
    end
    reset = 1'b0;
    exp_count = 0; exp_err = 1'b0;
    exp_q.delete(); obs_q.delete();
    d0 = done_cnt;
    for (int c = 61; c <= 70; c++) send_pixel(8'(c), 1, BC);
    send_open();
    send_body(0, 0, 159);
    send_open();
    wait_result(got, ok); e = pop_exp();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL mid_reset_frame: got %h expected %h", got, e); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL mid_reset_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_clean_collide();
    test_clear_jump();
    test_outside_window();
    test_back_to_back();
    test_short_frame();
    test_bad_pixel(1);
    test_bad_pixel(2);
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
